// File: rtl/conv_encoder.sv
// Rate-1/3 K=7 convolutional encoder (133/171/165 octal), zero-tail; tail-biting when CONV_ENC_TAIL_BITING_EN is defined.
// Latency: first codeword two cycles after the last info bit is accepted; then one codeword per cycle.
// Backpressure: code_o/sof_o/eof_o held while code_valid_o && !code_ready_i; input side is ready only while loading.
module conv_encoder #(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic             rst_sync_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] frame_len_i,
  input  logic             tail_biting_en,
  input  logic             data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic [2:0]       code_o,
  output logic             code_valid_o,
  input  logic             code_ready_i,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_PRIME  = 3'd2;
  localparam logic [2:0] ST_ENCODE = 3'd3;
  localparam logic [2:0] ST_TAIL   = 3'd4;

  logic [2:0]         state_q;
  logic [LEN_W-1:0]   last_q;
  logic               tb_q;
  logic [IDX_W-1:0]   wr_q;
  logic [IDX_W-1:0]   rd_q;
  logic [2:0]         tail_q;
  logic [5:0]         s_q;
  logic               gen_done_q;
  logic [2:0]         code_q;
  logic               vld_q;
  logic               sof_q;
  logic               eof_q;
  logic               err_q;
  logic [MAX_LEN-1:0] mem_q;

  logic       clear;
  logic       start_tb;
  logic       len_bad;
  logic       wr_last;
  logic       rd_last;
  logic       info_phase;
  logic       slot_free;
  logic       gen_fire;
  logic       gen_last;
  logic       gen_u;
  logic [5:0] gen_s;
  logic [5:0] prime_s;
  logic [2:0] gen_code;

  assign clear = rst_sync_i || !en_i;

`ifdef CONV_ENC_TAIL_BITING_EN
  assign start_tb = tail_biting_en;
`else
  logic unused_tail_biting;
  assign unused_tail_biting = tail_biting_en;
  assign start_tb = 1'b0;
`endif

  // Tail-biting needs a full 6-bit start state taken from the frame itself.
  assign len_bad = (frame_len_i == '0) ||
                   (frame_len_i > LEN_W'(MAX_LEN)) ||
                   (start_tb && (frame_len_i < LEN_W'(6)));

  assign wr_last    = (LEN_W'(wr_q) == last_q);
  assign rd_last    = (LEN_W'(rd_q) == last_q);
  assign info_phase = (state_q == ST_PRIME) || (state_q == ST_ENCODE);
  assign slot_free  = !vld_q || code_ready_i;

  // PRIME produces the first codeword directly from the start state, so the
  // output register is filled on the same edge the shift register is loaded.
  assign gen_fire = (state_q == ST_PRIME) ||
                    (((state_q == ST_ENCODE) || (state_q == ST_TAIL)) && !gen_done_q && slot_free);

  assign gen_last = info_phase ? (rd_last && tb_q) : (tail_q == 3'd5);

  always_comb begin
    prime_s = '0;
`ifdef CONV_ENC_TAIL_BITING_EN
    if (tb_q) begin
      for (int j = 0; j < 6; j++) begin
        prime_s[j] = mem_q[last_q[IDX_W-1:0] - IDX_W'(j)];
      end
    end
`endif
  end

  assign gen_s = (state_q == ST_PRIME) ? prime_s : s_q;
  assign gen_u = (state_q == ST_TAIL) ? 1'b0 : mem_q[rd_q];

  assign gen_code = {gen_u ^ gen_s[0] ^ gen_s[1] ^ gen_s[3] ^ gen_s[5],
                     gen_u ^ gen_s[0] ^ gen_s[1] ^ gen_s[2] ^ gen_s[5],
                     gen_u ^ gen_s[1] ^ gen_s[2] ^ gen_s[4] ^ gen_s[5]};

  always_ff @(posedge clk_i) begin
    if ((state_q == ST_LOAD) && data_valid_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q    <= ST_IDLE;
      last_q     <= '0;
      tb_q       <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      tail_q     <= '0;
      s_q        <= '0;
      gen_done_q <= 1'b0;
      code_q     <= '0;
      vld_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
    end else if (clear) begin
      state_q    <= ST_IDLE;
      last_q     <= '0;
      tb_q       <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      tail_q     <= '0;
      s_q        <= '0;
      gen_done_q <= 1'b0;
      code_q     <= '0;
      vld_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (len_bad) begin
              err_q <= 1'b1;
            end else begin
              last_q     <= frame_len_i - LEN_W'(1);
              tb_q       <= start_tb;
              wr_q       <= '0;
              rd_q       <= '0;
              tail_q     <= '0;
              gen_done_q <= 1'b0;
              state_q    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (data_valid_i) begin
            wr_q <= wr_q + IDX_W'(1);
            if (wr_last) begin
              state_q <= ST_PRIME;
            end
          end
        end
        default: begin
        end
      endcase

      if (gen_fire) begin
        code_q <= gen_code;
        vld_q  <= 1'b1;
        sof_q  <= (state_q == ST_PRIME);
        eof_q  <= gen_last;
        s_q    <= {gen_s[4:0], gen_u};
        if (info_phase) begin
          if (rd_last) begin
            if (tb_q) begin
              gen_done_q <= 1'b1;
              state_q    <= ST_ENCODE;
            end else begin
              tail_q  <= '0;
              state_q <= ST_TAIL;
            end
          end else begin
            rd_q    <= rd_q + IDX_W'(1);
            state_q <= ST_ENCODE;
          end
        end else begin
          tail_q <= tail_q + 3'd1;
          if (tail_q == 3'd5) begin
            gen_done_q <= 1'b1;
          end
        end
      end else if (vld_q && code_ready_i) begin
        vld_q <= 1'b0;
        sof_q <= 1'b0;
        eof_q <= 1'b0;
        // Handshake of the final codeword ends the frame.
        if (eof_q) begin
          gen_done_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      end
    end
  end

  assign data_ready_o = (state_q == ST_LOAD);
  assign code_o       = code_q;
  assign code_valid_o = vld_q;
  assign sof_o        = sof_q;
  assign eof_o        = eof_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;

endmodule
